// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: machine word and instruction-cache frame layout.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    // Default geometry: 16 one-word frames.
    localparam int IIDX_W = 4;
    localparam int ITAG_W = 32 - IIDX_W - 2;

    typedef struct packed {
        logic              valid;
        logic [ITAG_W-1:0] tag;
        word_t             data;
    } icache_frame_t;

endpackage

// File: rtl/icache.sv
// Direct-mapped, one-word-per-frame instruction cache.
// Hits return in the same cycle. A miss holds the datapath in FETCH until the memory controller returns the fill word.
module icache
    import cpu_types_pkg::*;
#(
    parameter int NSETS = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    input  logic        iflush,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload
);

    localparam int IDX_W = $clog2(NSETS);
    localparam int TAG_W = 30 - IDX_W;

    typedef enum logic {IDLE, FETCH} state_e;

    state_e            state_q, state_d;
    logic [29:0]       miss_q, miss_d;
    logic [NSETS-1:0]  valid_q, valid_d;
    logic [TAG_W-1:0]  tag_q  [NSETS];
    word_t             data_q [NSETS];

    logic [IDX_W-1:0]  req_idx, miss_idx;
    logic [TAG_W-1:0]  req_tag, miss_tag;
    logic              hit, fill_en;
    logic              unused_ok;

    assign req_idx   = imemaddr[IDX_W+1:2];
    assign req_tag   = imemaddr[31:IDX_W+2];
    assign miss_idx  = miss_q[IDX_W-1:0];
    assign miss_tag  = miss_q[29:IDX_W];
    assign unused_ok = ^imemaddr[1:0];

    assign hit      = (state_q == IDLE) && imemREN && valid_q[req_idx]
                      && (tag_q[req_idx] == req_tag) && !iflush;
    assign ihit     = hit;
    assign imemload = hit ? data_q[req_idx] : 32'h0;
    assign iREN     = (state_q == FETCH);
    assign iaddr    = (state_q == FETCH) ? {miss_q, 2'b00} : 32'h0;

    always_comb begin
        state_d = state_q;
        miss_d  = miss_q;
        valid_d = valid_q;
        fill_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (iflush) begin
                    valid_d = '0;
                end else if (imemREN && !hit) begin
                    miss_d  = imemaddr[31:2];
                    state_d = FETCH;
                end
            end
            FETCH: begin
                // Flush wins over a returning fill so a stale word is never installed.
                if (iflush) begin
                    valid_d = '0;
                    state_d = IDLE;
                end else if (!iwait) begin
                    fill_en           = 1'b1;
                    valid_d[miss_idx] = 1'b1;
                    state_d           = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            miss_q  <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            miss_q  <= miss_d;
            valid_q <= valid_d;
        end
    end

    // Tag/data storage carries no reset; valid_q alone qualifies it.
    always_ff @(posedge CLK) begin
        if (fill_en && !RST) begin
            tag_q[miss_idx]  <= miss_tag;
            data_q[miss_idx] <= iload;
        end
    end

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: cold miss, hit, conflict, mid-fetch address change, flush and reset.
module tb_icache;

    logic        CLK = 1'b0;
    logic        RST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iflush;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;

    int checks = 0;
    int errors = 0;

    icache #(.NSETS(16)) dut (
        .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr),
        .ihit(ihit), .imemload(imemload), .iflush(iflush), .iREN(iREN),
        .iaddr(iaddr), .iwait(iwait), .iload(iload)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Single-cycle lookup; imemREN drops before the edge so a miss is not latched.
    task automatic probe(input string tag, input logic [31:0] a, input logic h, input logic [31:0] d);
        imemREN  = 1'b1;
        imemaddr = a;
        @(negedge CLK);
        chk({tag, "_ihit"}, {31'h0, ihit}, {31'h0, h});
        chk({tag, "_load"}, imemload, h ? d : 32'h0);
        chk({tag, "_iren"}, {31'h0, iREN}, 32'h0);
        imemREN = 1'b0;
        step();
    endtask

    // Miss then fill with the given number of stall cycles before the data returns.
    task automatic fill(input string tag, input logic [31:0] a, input logic [31:0] d, input int waits);
        imemREN  = 1'b1;
        imemaddr = a;
        iwait    = 1'b1;
        @(negedge CLK);
        chk({tag, "_miss"}, {31'h0, ihit}, 32'h0);
        step();
        for (int w = 0; w <= waits; w++) begin
            if (w == waits) begin
                iwait = 1'b0;
                iload = d;
            end
            @(negedge CLK);
            chk({tag, "_iren"}, {31'h0, iREN}, 32'h1);
            chk({tag, "_iaddr"}, iaddr, {a[31:2], 2'b00});
            chk({tag, "_nohit"}, {31'h0, ihit}, 32'h0);
            step();
        end
        iwait   = 1'b1;
        imemREN = 1'b0;
    endtask

    initial begin
        RST = 1'b1; imemREN = 1'b0; imemaddr = 32'h0; iflush = 1'b0; iwait = 1'b1; iload = 32'h0;
        @(negedge CLK);
        chk("rst_ihit", {31'h0, ihit}, 32'h0);
        chk("rst_iren", {31'h0, iREN}, 32'h0);
        chk("rst_iaddr", iaddr, 32'h0);
        chk("rst_load", imemload, 32'h0);
        step();
        RST = 1'b0;

        // Cold miss with three stall cycles, then the hit on the following cycle.
        fill("cold", 32'h0000_0040, 32'hDEAD_BEEF, 3);
        probe("cold_hit", 32'h0000_0040, 1'b1, 32'hDEAD_BEEF);
        probe("hit42", 32'h0000_0042, 1'b1, 32'hDEAD_BEEF);

        // Conflict in frame 0 evicts the earlier line.
        probe("conf_miss", 32'h0000_0080, 1'b0, 32'h0);
        fill("conf", 32'h0000_0080, 32'h1234_5678, 0);
        probe("conf_hit", 32'h0000_0080, 1'b1, 32'h1234_5678);
        probe("conf_evict", 32'h0000_0040, 1'b0, 32'h0);

        // Address moves and imemREN drops mid-fetch; fill still targets 0x44.
        imemREN = 1'b1; imemaddr = 32'h0000_0044; iwait = 1'b1;
        step();
        imemaddr = 32'h0000_0100;
        @(negedge CLK);
        chk("mv_iaddr0", iaddr, 32'h0000_0044);
        step();
        imemREN = 1'b0;
        @(negedge CLK);
        chk("mv_iaddr1", iaddr, 32'h0000_0044);
        iwait = 1'b0; iload = 32'hCAFE_F00D;
        step();
        iwait = 1'b1;
        probe("mv_hit44", 32'h0000_0044, 1'b1, 32'hCAFE_F00D);
        probe("mv_miss100", 32'h0000_0100, 1'b0, 32'h0);
        probe("mv_keep80", 32'h0000_0080, 1'b1, 32'h1234_5678);

        // Flush in IDLE forces ihit low that cycle and clears every frame.
        fill("fl", 32'h0000_0040, 32'hDEAD_BEEF, 1);
        imemREN = 1'b1; imemaddr = 32'h0000_0040; iflush = 1'b1;
        @(negedge CLK);
        chk("fl_ihit", {31'h0, ihit}, 32'h0);
        chk("fl_load", imemload, 32'h0);
        imemREN = 1'b0;
        step();
        iflush = 1'b0;
        probe("fl_miss40", 32'h0000_0040, 1'b0, 32'h0);
        probe("fl_miss44", 32'h0000_0044, 1'b0, 32'h0);

        // Flush while fetching aborts even with data returning.
        imemREN = 1'b1; imemaddr = 32'h0000_0048; iwait = 1'b1;
        step();
        iflush = 1'b1; iwait = 1'b0; iload = 32'h5555_5555;
        @(negedge CLK);
        chk("flf_iren_on", {31'h0, iREN}, 32'h1);
        imemREN = 1'b0;
        step();
        iflush = 1'b0; iwait = 1'b1;
        @(negedge CLK);
        chk("flf_iren_off", {31'h0, iREN}, 32'h0);
        step();
        probe("flf_miss48", 32'h0000_0048, 1'b0, 32'h0);

        // Reset mid-fetch drops iREN immediately and invalidates everything.
        fill("rf40", 32'h0000_0040, 32'hDEAD_BEEF, 0);
        fill("rf44", 32'h0000_0044, 32'hCAFE_F00D, 0);
        probe("rf_hit44", 32'h0000_0044, 1'b1, 32'hCAFE_F00D);
        imemREN = 1'b1; imemaddr = 32'h0000_004C; iwait = 1'b1;
        step();
        @(negedge CLK);
        chk("rf_iren_on", {31'h0, iREN}, 32'h1);
        #2;
        RST = 1'b1; imemREN = 1'b0;
        #1;
        chk("rf_iren_off", {31'h0, iREN}, 32'h0);
        chk("rf_iaddr", iaddr, 32'h0);
        step();
        RST = 1'b0;
        probe("rf_miss40", 32'h0000_0040, 1'b0, 32'h0);
        probe("rf_miss44", 32'h0000_0044, 1'b0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
